alu_op_sequencer: RTL and testbench

//  Command-driven FSM that sequences the Bit6Alu datapath. It accepts one command
//  (operand select, carry-in, carry mode, repeat count) through a start/busy/done

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_rep_cnt.sv | 39 +++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: state encoding,
// Mux1/Mux2 select codes, command record and default widths.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Mux1 (operand) select codes
    localparam logic [1:0] OPT_R2   = 2'b00;
    localparam logic [1:0] OPT_NR2  = 2'b01;
    localparam logic [1:0] OPT_R1   = 2'b10;
    localparam logic [1:0] OPT_ONES = 2'b11;

    // Mux2 (carry flip-flop source) select codes
    localparam logic [1:0] CSEL_ZERO = 2'b00;
    localparam logic [1:0] CSEL_HOLD = 2'b01;
    localparam logic [1:0] CSEL_SEED = 2'b10;
    localparam logic [1:0] CSEL_COUT = 2'b11;

    // Command fields captured when a start is accepted
    typedef struct packed {
        logic [1:0] opt;
        logic       cin;
        logic       chain;
    } cmd_t;

endpackage

// File: rtl/alu_seq_rep_cnt.sv
// Loadable down-counter for the EXEC repeat count. 'last' flags the final
// EXEC cycle (count == 1). The counter stops at zero.
module alu_seq_rep_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement; never wrap below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for the Bit6Alu datapath.
// IDLE -> LOAD -> EXEC (x max(rep,1)) -> DONE -> IDLE, Moore outputs decoded
// from the state register and the latched command.
// Optional feature: define ALU_SEQ_OVF_EN to build the sticky carry-out
// flag 'ovf'; otherwise ovf is tied low and fa_cout is ignored.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cmd_opt,
    input  logic             cmd_cin,
    input  logic             cmd_chain,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             fa_cout,
    output logic             load,
    output logic             hold,
    output logic             shift,
    output logic [1:0]       opt,
    output logic             opt2,
    output logic [1:0]       c,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic             accept;
    logic             cnt_last;
    logic [REP_W-1:0] rep_eff;

    // A start is only seen in IDLE; anywhere else it is dropped, not queued.
    assign accept  = (state_q == ST_IDLE) && start;
    // A repeat count of zero still executes one write-back cycle.
    assign rep_eff = (cmd_rep == '0) ? REP_W'(1) : cmd_rep;

    alu_seq_rep_cnt #(
        .W (REP_W)
    ) u_rep_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (rep_eff),
        .dec      (state_q == ST_EXEC),
        .last     (cnt_last)
    );

    // Next state and command capture
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d   = '{opt: cmd_opt, cin: cmd_cin, chain: cmd_chain};
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: if (cnt_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and command registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // Moore output decode; idle/done defaults keep the datapath holding
    always_comb begin
        load  = 1'b0;
        hold  = 1'b1;
        shift = 1'b0;
        opt   = OPT_R2;
        opt2  = 1'b0;
        c     = CSEL_ZERO;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load = 1'b1;
                hold = 1'b0;
                opt  = cmd_q.opt;
                opt2 = cmd_q.cin;
                c    = CSEL_SEED;
                busy = 1'b1;
            end
            ST_EXEC: begin
                shift = 1'b1;
                hold  = 1'b0;
                opt   = cmd_q.opt;
                opt2  = cmd_q.cin;
                c     = cmd_q.chain ? CSEL_COUT : CSEL_SEED;
                busy  = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky carry-out: cleared entering LOAD, accumulates over EXEC
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (state_q == ST_EXEC) begin
            ovf_d = ovf_q | fa_cout;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_fa_cout;
    assign unused_fa_cout = fa_cout;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer paired with a behavioural Bit6Alu datapath.
// Expected results come from an arithmetic model of each command.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int RW = DEF_REP_W;
    localparam int MOD = 2 ** W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    cmd_opt;
    logic          cmd_cin;
    logic          cmd_chain;
    logic [RW-1:0] cmd_rep;
    logic          fa_cout;
    logic          load, hold, shift;
    logic [1:0]    opt;
    logic          opt2;
    logic [1:0]    c;
    logic          busy, done, ovf;

    logic [W-1:0]  a_in, b_in;
    logic [W-1:0]  dp_r1, dp_r2, dp_mux1;
    logic          dp_q;
    logic [W:0]    dp_sum;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmd_opt   (cmd_opt),
        .cmd_cin   (cmd_cin),
        .cmd_chain (cmd_chain),
        .cmd_rep   (cmd_rep),
        .fa_cout   (fa_cout),
        .load      (load),
        .hold      (hold),
        .shift     (shift),
        .opt       (opt),
        .opt2      (opt2),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    // Bit6Alu datapath: R1, R2, carry FF, Mux1, Mux2, full adder
    always_comb begin
        case (opt)
            2'b00:   dp_mux1 = dp_r2;
            2'b01:   dp_mux1 = ~dp_r2;
            2'b10:   dp_mux1 = dp_r1;
            default: dp_mux1 = '1;
        endcase
        dp_sum = {1'b0, dp_r1} + {1'b0, dp_mux1} + (W+1)'(dp_q);
    end
    assign fa_cout = dp_sum[W];

    always @(posedge clk) begin
        if (load) begin
            dp_r1 <= a_in;
            dp_r2 <= b_in;
        end else if (shift) begin
            dp_r1 <= dp_sum[W-1:0];
        end
        case (c)
            2'b00:   dp_q <= 1'b0;
            2'b01:   dp_q <= dp_q;
            2'b10:   dp_q <= opt2;
            default: dp_q <= fa_cout;
        endcase
    end

    // Command result computed from the arithmetic definition
    function automatic void ref_cmd(input int a, input int b, input int o,
                                    input int cin, input int chain, input int n,
                                    output logic [W-1:0] r1, output logic ov);
        int acc, operand, carry, s;
        acc   = a;
        carry = cin;
        ov    = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (o)
                0:       operand = b;
                1:       operand = (MOD - 1) - b;
                2:       operand = acc;
                default: operand = MOD - 1;
            endcase
            s     = acc + operand + carry;
            ov    = ov | (s >= MOD);
            acc   = s % MOD;
            carry = (chain != 0) ? ((s >= MOD) ? 1 : 0) : cin;
        end
        r1 = W'(acc);
    endfunction

    // Run one command and check every cycle from LOAD through the idle tail.
    // keep_start holds start high through busy and the DONE cycle.
    task automatic run_cmd(input string name, input int a, input int b, input int o,
                           input int cin, input int chain, input int rep,
                           input bit keep_start);
        int           n;
        int           done_k;
        logic [W-1:0] exp_r1;
        logic         exp_ov;
        logic [4:0]   exp_ctl;
        logic [3:0]   exp_sel;
        n      = (rep == 0) ? 1 : rep;
        done_k = -1;
        ref_cmd(a, b, o, cin, chain, n, exp_r1, exp_ov);
`ifndef ALU_SEQ_OVF_EN
        exp_ov = 1'b0;
`endif
        @(negedge clk);
        a_in      = W'(a);
        b_in      = W'(b);
        cmd_opt   = 2'(o);
        cmd_cin   = 1'(cin);
        cmd_chain = 1'(chain);
        cmd_rep   = RW'(rep);
        start     = 1'b1;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (!keep_start) start = 1'b0;
            cmd_opt   = 2'($urandom);
            cmd_cin   = 1'($urandom);
            cmd_chain = 1'($urandom);
            cmd_rep   = RW'($urandom);
            if (done) done_k = k;
            // {load, hold, shift, busy, done}
            if (k == 1) begin
                exp_ctl = 5'b10010;
                exp_sel = {2'(o), CSEL_SEED};
            end else if (k <= n + 1) begin
                exp_ctl = 5'b00110;
                exp_sel = {2'(o), (chain != 0) ? CSEL_COUT : CSEL_SEED};
            end else begin
                exp_ctl = 5'b01001;
                exp_sel = {opt, c};
            end
            tests_run++;
            if ({load, hold, shift, busy, done} !== exp_ctl) begin
                tests_failed++;
                $display("FAIL %s ctl cycle %0d: got %b expected %b", name, k,
                         {load, hold, shift, busy, done}, exp_ctl);
            end
            if (k <= n + 1) begin
                tests_run++;
                if ({opt, c} !== exp_sel) begin
                    tests_failed++;
                    $display("FAIL %s opt/c cycle %0d: got %b expected %b", name, k,
                             {opt, c}, exp_sel);
                end
                if (k == 1 || chain == 0) begin
                    tests_run++;
                    if (opt2 !== 1'(cin)) begin
                        tests_failed++;
                        $display("FAIL %s opt2 cycle %0d: got %b expected %b", name, k,
                                 opt2, 1'(cin));
                    end
                end
            end
        end
        tests_run++;
        if (done_k != n + 2) begin
            tests_failed++;
            $display("FAIL %s done latency: got %0d expected %0d", name, done_k, n + 2);
        end
        tests_run++;
        if (dp_r1 !== exp_r1) begin
            tests_failed++;
            $display("FAIL %s R1: got %0d expected %0d", name, dp_r1, exp_r1);
        end
        tests_run++;
        if (ovf !== exp_ov) begin
            tests_failed++;
            $display("FAIL %s ovf: got %b expected %b", name, ovf, exp_ov);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            tests_run++;
            if ({load, hold, shift, busy, done} !== 5'b01000) begin
                tests_failed++;
                $display("FAIL %s idle tail %0d: got %b expected 01000", name, k,
                         {load, hold, shift, busy, done});
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        tests_run++;
        if ({load, hold, shift, opt, opt2, c, busy, done, ovf} !== 12'b010_00_0_00_000) begin
            tests_failed++;
            $display("FAIL %s reset outputs: got %b expected 010000000000", name,
                     {load, hold, shift, opt, opt2, c, busy, done, ovf});
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        start     = 1'b0;
        cmd_opt   = '0;
        cmd_cin   = 1'b0;
        cmd_chain = 1'b0;
        cmd_rep   = '0;
        a_in      = '0;
        b_in      = '0;
        #1;
        check_reset_values("reset_async");
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_reset_values("reset_held");
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_released");
    endtask

    task automatic test_directed();
        run_cmd("add",        5,  3, 0, 0, 0, 1, 1'b0);
        run_cmd("sub",        9,  4, 1, 1, 0, 1, 1'b0);
        run_cmd("repeat_add", 2,  3, 0, 0, 0, 4, 1'b0);
        run_cmd("rep_zero",  63,  0, 3, 0, 0, 0, 1'b0);
        run_cmd("chain_add", 40, 30, 0, 1, 1, 3, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_cmd("start_held", 7, 11, 0, 0, 1, 3, 1'b1);
    endtask

    task automatic test_reset_abort();
        int seen_busy;
        int seen_done;
        seen_busy = 0;
        seen_done = 0;
        @(negedge clk);
        a_in      = 6'd10;
        b_in      = 6'd1;
        cmd_opt   = OPT_R2;
        cmd_cin   = 1'b0;
        cmd_chain = 1'b0;
        cmd_rep   = RW'(5);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (shift !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort precondition: shift got %b expected 1", shift);
        end
        reset = 1'b0;
        #1;
        check_reset_values("abort_immediate");
        @(negedge clk);
        check_reset_values("abort_held");
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) seen_busy++;
            if (done) seen_done++;
        end
        tests_run++;
        if (seen_busy != 0 || seen_done != 0) begin
            tests_failed++;
            $display("FAIL abort aftermath: busy %0d done %0d expected 0 0", seen_busy, seen_done);
        end
        run_cmd("after_abort", 12, 5, 0, 1, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_cmd("random", int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 2 ** RW - 1)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int first;
        int second;
        n      = 3;
        first  = -1;
        second = -1;
        @(negedge clk);
        a_in      = 6'd1;
        b_in      = 6'd2;
        cmd_opt   = OPT_R2;
        cmd_cin   = 1'b0;
        cmd_chain = 1'b0;
        cmd_rep   = RW'(n);
        start     = 1'b1;
        for (int k = 1; k <= 4 * (n + 3); k++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        start = 1'b0;
        repeat (n + 4) @(negedge clk);
        tests_run++;
        if (first != n + 2) begin
            tests_failed++;
            $display("FAIL b2b first done: got %0d expected %0d", first, n + 2);
        end
        tests_run++;
        if (second - first != n + 3) begin
            tests_failed++;
            $display("FAIL b2b spacing: got %0d expected %0d", second - first, n + 3);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
